// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR holding registers plus a request/acknowledge
// handshake towards a variable-latency memory, with optional bounded wait.
//
// state | meaning
// IDLE  | no access; MAR may be loaded, MIO_EN starts an access
// REQ   | Mem_Req high, waiting for Mem_Ack or for the wait budget to run out
// DONE  | access finished, Ready high until MIO_EN is released
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Bus_In,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              Ready,
  output logic              Err,
  output logic              Mem_Req,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_RData
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start, ack_hit, to_hit;
  logic [ADDR_W-1:0] bus_addr;

  // Address taken from the low bus bits, zero-extended when the bus is narrower.
  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      logic bus_hi_unused;
      assign bus_addr      = Bus_In[ADDR_W-1:0];
      assign bus_hi_unused = ^Bus_In;
    end else begin : g_addr_ext
      assign bus_addr = {{(ADDR_W - DATA_W){1'b0}}, Bus_In};
    end
  endgenerate

  assign Ready     = (state_q == DONE);
  assign Mem_Addr  = MAR;
  assign Mem_WData = MDR;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; acknowledge wins over an expiring wait budget.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          state_d = REQ;
          start   = 1'b1;
        end
      end
      REQ: begin
        if (Mem_Ack) begin
          state_d = DONE;
          ack_hit = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          to_hit  = 1'b1;
        end
      end
      DONE: begin
        if (!MIO_EN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, error flag and saturating wait counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mem_Req <= 1'b0;
      Mem_WE  <= 1'b0;
      Err     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      Mem_Req <= (state_d == REQ);
      if (start) begin
        Mem_WE <= R_W;
        Err    <= 1'b0;
        cnt_q  <= '0;
      end else begin
        if (state_d != REQ) Mem_WE <= 1'b0;
        if (to_hit) Err <= 1'b1;
        if ((state_q == REQ) && !Mem_Ack && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // MAR loads only in IDLE, so an access always uses the address seen at its start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                          MAR <= '0;
    else if ((state_q == IDLE) && LD_MAR) MAR <= bus_addr;
  end

  // MDR: read data on acknowledge, bus load only while no access is requested.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                  MDR <= '0;
    else if (ack_hit && !Mem_WE)   MDR <= Mem_RData;
    else if (LD_MDR && !MIO_EN)    MDR <= Bus_In;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TO_A = 4;

  logic        clk, rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
  logic        ready, err, mem_req, mem_we, mem_ack;

  logic [31:0] bus_in_b, mdr_b, mem_wdata_b, mem_rdata_b;
  logic        ld_mar_b, ld_mdr_b, mio_en_b, r_w_b;
  logic [11:0] mar_b, mem_addr_b;
  logic        ready_b, err_b, mem_req_b, mem_we_b, mem_ack_b;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model of the architectural registers
  logic [15:0] m_mar, m_mdr;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO_A)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .Bus_In(bus_in), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .MIO_EN(mio_en), .R_W(r_w), .MAR(mar), .MDR(mdr), .Ready(ready), .Err(err),
    .Mem_Req(mem_req), .Mem_WE(mem_we), .Mem_Addr(mem_addr), .Mem_WData(mem_wdata),
    .Mem_Ack(mem_ack), .Mem_RData(mem_rdata)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(12), .TIMEOUT(0)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Bus_In(bus_in_b), .LD_MAR(ld_mar_b), .LD_MDR(ld_mdr_b),
    .MIO_EN(mio_en_b), .R_W(r_w_b), .MAR(mar_b), .MDR(mdr_b), .Ready(ready_b), .Err(err_b),
    .Mem_Req(mem_req_b), .Mem_WE(mem_we_b), .Mem_Addr(mem_addr_b), .Mem_WData(mem_wdata_b),
    .Mem_Ack(mem_ack_b), .Mem_RData(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access seen from the control side, checked cycle by cycle
  // against latency/outcome computed from the access rules.
  task automatic do_access(input bit rw, input logic [15:0] addr, input logic [15:0] wdata,
                           input int n_wait, input logic [15:0] rdata, input int hold);
    bit to;
    int req_cycles;
    logic [15:0] exp_mdr;
    to         = (TO_A != 0) && (n_wait >= TO_A);
    req_cycles = to ? TO_A : n_wait + 1;
    bus_in = addr; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0; m_mar = addr;
    if (rw) begin
      bus_in = wdata; ld_mdr = 1'b1;
      tick();
      ld_mdr = 1'b0; m_mdr = wdata;
    end
    exp_mdr = (!rw && !to) ? rdata : m_mdr;
    mio_en = 1'b1; r_w = rw; mem_ack = 1'b0;
    tick();
    // mid-access disturbances that must have no effect
    r_w = ~rw; ld_mar = 1'b1; ld_mdr = 1'b1; bus_in = 16'($urandom);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL err_clear_on_start: got %b want 0", err);
    end
    for (int c = 0; c < req_cycles; c++) begin
      n_vec++;
      if ({mem_req, mem_we, ready} !== {1'b1, rw, 1'b0}) begin
        n_err++;
        $display("FAIL req_phase c=%0d: req/we/ready got %b%b%b want 1%b0", c, mem_req, mem_we, ready, rw);
      end
      n_vec++;
      if ({mem_addr, mem_wdata} !== {m_mar, m_mdr}) begin
        n_err++;
        $display("FAIL req_bus c=%0d: addr/wdata got %h/%h want %h/%h", c, mem_addr, mem_wdata, m_mar, m_mdr);
      end
      mem_ack   = (!to && c == n_wait);
      mem_rdata = mem_ack ? rdata : 16'($urandom);
      tick();
    end
    mem_ack = 1'b0;
    m_mdr = exp_mdr;
    n_vec++;
    if ({ready, err, mem_req, mem_we} !== {1'b1, to, 2'b00}) begin
      n_err++;
      $display("FAIL done: ready/err/req/we got %b%b%b%b want 1%b00", ready, err, mem_req, mem_we, to);
    end
    n_vec++;
    if ({mar, mdr} !== {m_mar, m_mdr}) begin
      n_err++;
      $display("FAIL done_regs: mar/mdr got %h/%h want %h/%h", mar, mdr, m_mar, m_mdr);
    end
    for (int h = 0; h < hold; h++) begin
      mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      tick();
      n_vec++;
      if ({ready, mem_req, mar, mdr} !== {2'b10, m_mar, m_mdr}) begin
        n_err++;
        $display("FAIL hold h=%0d: ready/req/mar/mdr got %b%b/%h/%h want 10/%h/%h",
                 h, ready, mem_req, mar, mdr, m_mar, m_mdr);
      end
    end
    mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; mem_ack = 1'b0;
    tick();
    n_vec++;
    if ({ready, mem_req, err} !== {2'b00, to}) begin
      n_err++;
      $display("FAIL back_to_idle: ready/req/err got %b%b%b want 00%b", ready, mem_req, err, to);
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({mar, mdr, mem_req, mem_we, ready, err} !== '0) begin
      n_err++;
      $display("FAIL reset_values: mar/mdr/req/we/ready/err got %h/%h/%b%b%b%b want all 0",
               mar, mdr, mem_req, mem_we, ready, err);
    end
    bus_in = 16'h1111; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
    bus_in = 16'h2222; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
    mio_en = 1'b1; r_w = 1'b1;
    tick(); tick();
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_req: got %b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mar, mdr, mem_req, ready, err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: mar/mdr/req/ready/err got %h/%h/%b%b%b want all 0",
               mar, mdr, mem_req, ready, err);
    end
    mio_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({ready, mem_req, mem_we} !== 3'b000) begin
      n_err++; $display("FAIL reset_release_idle: ready/req/we got %b%b%b want 000", ready, mem_req, mem_we);
    end
    m_mar = '0; m_mdr = '0;
  endtask

  task automatic test_read_zero_wait;
    do_access(1'b0, 16'h3000, 16'h0, 0, 16'hBEEF, 0);
  endtask

  task automatic test_write_waits;
    do_access(1'b1, 16'h4001, 16'h1234, 3, 16'hFFFF, 0);
  endtask

  task automatic test_timeout;
    do_access(1'b0, 16'h5555, 16'h0, 50, 16'hAAAA, 1);
    do_access(1'b0, 16'h5556, 16'h0, 1, 16'h0F0F, 0);
  endtask

  task automatic test_hold;
    do_access(1'b1, 16'h6000, 16'hCAFE, 2, 16'h0, 5);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++)
      do_access(1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 6),
                16'($urandom), $urandom_range(0, 3));
  endtask

  task automatic test_param_sweep;
    bus_in_b = 32'h12345FFF; ld_mar_b = 1'b1; tick(); ld_mar_b = 1'b0;
    n_vec++;
    if (mar_b !== 12'hFFF) begin
      n_err++; $display("FAIL sweep_mar_trunc: got %h want fff", mar_b);
    end
    bus_in_b = 32'h00000ABC; ld_mar_b = 1'b1; tick(); ld_mar_b = 1'b0;
    mio_en_b = 1'b1; r_w_b = 1'b0;
    tick();
    for (int c = 0; c < 300; c++) begin
      mem_rdata_b = $urandom;
      tick();
    end
    n_vec++;
    if ({mem_req_b, ready_b, err_b, mem_addr_b} !== {3'b100, 12'hABC}) begin
      n_err++;
      $display("FAIL sweep_no_timeout: req/ready/err/addr got %b%b%b/%h want 100/abc",
               mem_req_b, ready_b, err_b, mem_addr_b);
    end
    mem_ack_b = 1'b1; mem_rdata_b = 32'hDEADBEEF;
    tick();
    mem_ack_b = 1'b0;
    n_vec++;
    if ({ready_b, err_b, mem_req_b, mdr_b} !== {3'b100, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL sweep_read: ready/err/req/mdr got %b%b%b/%h want 100/deadbeef",
               ready_b, err_b, mem_req_b, mdr_b);
    end
    mio_en_b = 1'b0;
    tick();
    n_vec++;
    if (ready_b !== 1'b0) begin
      n_err++; $display("FAIL sweep_idle: ready got %b want 0", ready_b);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    bus_in_b = '0; ld_mar_b = 1'b0; ld_mdr_b = 1'b0; mio_en_b = 1'b0; r_w_b = 1'b0;
    mem_ack_b = 1'b0; mem_rdata_b = '0;
    m_mar = '0; m_mdr = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_timeout();
    test_hold();
    test_random();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
